// File: rtl/bit_serial_alu.sv
// bit_serial_alu: LSB-first bit-serial ALU, one operand bit per enabled clock.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   ena    : clock enable, 0 freezes all state
//   start  : request, accepted in IDLE or DONE
//   op     : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SHL, 111 SHR
//   a, b   : operands, latched on accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result and flags valid from this cycle
//   result : registered result, held until the next done
//   carry  : carry / no-borrow / shifted-out bit, persistent across operations
//   zero   : result == 0
//   ovf    : signed overflow for ADD/SUB/ADC, else 0
module bit_serial_alu #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4, OP_ADC = 3'd5, OP_SHL = 3'd6, OP_SHR = 3'd7;

   state_t           r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b;
   logic [WIDTH-2:0] r_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_c, r_z;

   logic             w_a0, w_b0, w_sum, w_maj, w_arith, w_logic, w_bit, w_cn, w_last, w_cin;
   logic [WIDTH-1:0] w_res;

   always_comb begin
      w_a0    = r_a[0];
      w_b0    = (r_op == OP_SUB) ? ~r_b[0] : r_b[0];
      w_sum   = w_a0 ^ w_b0 ^ r_c;
      w_maj   = (w_a0 & w_b0) | (r_c & (w_a0 ^ w_b0));
      w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_ADC);
      w_logic = (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_XOR);
      // SHL emits the previous A bit (held in r_c); SHR looks one bit ahead in the A shifter
      w_bit   = w_arith           ? w_sum :
                (r_op == OP_AND)  ? w_a0 & w_b0 :
                (r_op == OP_OR)   ? w_a0 | w_b0 :
                (r_op == OP_XOR)  ? w_a0 ^ w_b0 :
                (r_op == OP_SHL)  ? r_c : r_a[1];
      // For SHR r_c was preloaded with a[0] at start and simply holds
      w_cn    = w_arith ? w_maj : (r_op == OP_SHL) ? w_a0 : r_c;
      w_res   = {w_bit, r_res};
      w_last  = (r_cnt == CNT_W'(WIDTH - 1));
      w_cin   = (op == OP_SUB) ? 1'b1 : (op == OP_ADC) ? carry : (op == OP_SHR) ? a[0] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_c     <= 1'b0;
         r_z     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         ovf     <= 1'b0;
      end else if (ena) begin
         case (r_state)
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_res <= w_res[WIDTH-1:1];
               r_c   <= w_cn;
               r_z   <= r_z | w_bit;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  result  <= w_res;
                  carry   <= w_logic ? carry : w_cn;
                  zero    <= ~(r_z | w_bit);
                  // carry into MSB is r_c, carry out of MSB is w_cn
                  ovf     <= w_arith & (r_c ^ w_cn);
               end
            end
            default: begin
               done <= 1'b0;
               if (start) begin
                  r_state <= S_RUN;
                  busy    <= 1'b1;
                  r_op    <= op;
                  r_a     <= a;
                  r_b     <= b;
                  r_c     <= w_cin;
                  r_z     <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: randomized and directed checks of bit_serial_alu against an arithmetic model.
module tb_bit_serial_alu;
   logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0;
   logic [2:0]  op = '0;
   logic [7:0]  a = '0, b = '0;
   logic        busy, done, carry, zero, ovf;
   logic [7:0]  result;

   logic        s_start = 1'b0;
   logic [15:0] s_a = '0, s_b = '0;
   logic        s_busy, s_done, s_carry, s_zero, s_ovf;
   logic [15:0] s_result;

   int n_chk = 0, n_fail = 0;
   bit chk_on = 0;

   bit_serial_alu #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .ovf(ovf));

   bit_serial_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .ena(1'b1), .start(s_start), .op(3'd0), .a(s_a), .b(s_b),
      .busy(s_busy), .done(s_done), .result(s_result), .carry(s_carry), .zero(s_zero), .ovf(s_ovf));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // returns {ovf, carry, result}
   function automatic logic [9:0] ref_op(input logic [2:0] o, input logic [7:0] x, y, input logic cf);
      logic [8:0] s;
      logic [7:0] r;
      logic c, v;
      c = cf; v = 1'b0; r = '0; s = '0;
      case (o)
         3'd0: s = {1'b0, x} + {1'b0, y};
         3'd1: s = {1'b0, x} + {1'b0, ~y} + 9'd1;
         3'd5: s = {1'b0, x} + {1'b0, y} + {8'd0, cf};
         default: s = '0;
      endcase
      case (o)
         3'd0, 3'd5: begin r = s[7:0]; c = s[8]; v = (x[7] == y[7]) && (r[7] != x[7]); end
         3'd1: begin r = s[7:0]; c = s[8]; v = (x[7] != y[7]) && (r[7] != x[7]); end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd6: begin r = x << 1; c = x[7]; end
         default: begin r = x >> 1; c = x[0]; end
      endcase
      return {v, c, r};
   endfunction

   logic       m_busy, m_done, m_carry, m_zero, m_ovf;
   logic [7:0] m_res;
   logic [9:0] m_pend;
   int         m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_carry = 0; m_zero = 0; m_ovf = 0; m_res = 0; m_left = 0; m_pend = 0;
      end else if (ena) begin
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1;
               {m_ovf, m_carry, m_res} = m_pend;
               m_zero = (m_pend[7:0] == 8'd0);
            end
         end else begin
            m_done = 0;
            if (start) begin
               m_busy = 1; m_left = 8;
               m_pend = ref_op(op, a, b, m_carry);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_on) begin
         chk("m_busy", busy, m_busy);
         chk("m_done", done, m_done);
         chk("m_result", result, m_res);
         chk("m_carry", carry, m_carry);
         chk("m_zero", zero, m_zero);
         chk("m_ovf", ovf, m_ovf);
      end
   end

   // Call at least 1 time unit after a rising edge with the DUT idle or in DONE.
   task automatic op8(input logic [2:0] o, input logic [7:0] x, y, input bit noisy, input int en,
                      input logic [7:0] er, input logic ec, ez, ev);
      int n;
      start = 1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 0; n = 0;
      while (!done && n < 40) begin
         if (noisy) begin
            ena = !(n >= 3 && n < 6);
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      start = 0; ena = 1;
      chk("latency", n, en);
      chk("result", result, er);
      chk("carry", carry, ec);
      chk("zero", zero, ez);
      chk("ovf", ovf, ev);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
      chk("rst_carry", carry, 0); chk("rst_zero", zero, 0); chk("rst_ovf", ovf, 0);
      @(posedge clk); #2;
      rst_n = 1; chk_on = 1;
      @(posedge clk); #1;

      op8(3'd0, 8'h7F, 8'h01, 0, 8, 8'h80, 0, 0, 1);
      op8(3'd1, 8'h05, 8'h05, 0, 8, 8'h00, 1, 1, 0);
      op8(3'd1, 8'h03, 8'h05, 0, 8, 8'hFE, 0, 0, 0);
      op8(3'd0, 8'hFF, 8'h01, 0, 8, 8'h00, 1, 1, 0);
      op8(3'd5, 8'h10, 8'h20, 0, 8, 8'h31, 0, 0, 0);
      op8(3'd6, 8'h81, 8'h00, 0, 8, 8'h02, 1, 0, 0);
      op8(3'd7, 8'h81, 8'h00, 0, 8, 8'h40, 1, 0, 0);
      op8(3'd2, 8'hF0, 8'h3C, 0, 8, 8'h30, 1, 0, 0);
      op8(3'd0, 8'h12, 8'h34, 1, 11, 8'h46, 0, 0, 0);

      ena = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("done_hold", done, 1);
      ena = 1;
      @(posedge clk); #1;
      chk("done_drop", done, 0);

      start = 1; op = 3'd0; a = 8'hAA; b = 8'h55;
      @(posedge clk); #1;
      start = 0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_result", result, 0);
      chk("mid_rst_carry", carry, 0); chk("mid_rst_zero", zero, 0); chk("mid_rst_ovf", ovf, 0);
      @(posedge clk); #2;
      rst_n = 1;
      @(posedge clk); #1;
      op8(3'd0, 8'h01, 8'h01, 0, 8, 8'h02, 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         ena = ($urandom % 4) != 0;
         start = 1'($urandom); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
         @(posedge clk); #1;
      end
      ena = 1; start = 0;
      repeat (12) @(posedge clk);
      #1;

      s_a = 16'hFFFF; s_b = 16'h0001; s_start = 1;
      @(posedge clk); #1;
      s_start = 0; n = 0;
      while (!s_done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w16_latency", n, 16);
      chk("w16_result", s_result, 16'h0000);
      chk("w16_carry", s_carry, 1);
      chk("w16_zero", s_zero, 1);
      chk("w16_ovf", s_ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Parametrised, multi-cycle successor to the team's combinational 8-bit ALU: processes operands LSB-first, one bit per clock, through a single-bit datapath for area savings on TinyTapeout.
- Adds a start/done handshake, carry/zero/overflow flags, a persistent carry for multi-word arithmetic, shift operations and a clock-enable stall.
- Sits between the CPU control FSM and the register file of the bit-serial CPU.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2 to 32).
- CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  clock enable; 0 freezes all state.
- start  input  1  request; sampled only when not busy.
- op  input  3  operation select; latched on start.
- a  input  WIDTH  operand A; latched on start.
- b  input  WIDTH  operand B; latched on start.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  registered result; held until the next done.
- carry  output  1  carry/no-borrow/shifted-out bit; persistent.
- zero  output  1  high when result == 0.
- ovf  output  1  signed overflow (ADD/SUB/ADC only, else 0).

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, result=0, carry=0, zero=0, ovf=0, counter=0, operand shift registers=0.
- Operation encoding:
  - 000 ADD: a+b, cin=0.
  - 001 SUB: a+~b, cin=1; carry=1 means no borrow.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 ADC: a+b+carry_flag.
  - 110 SHL: result=a<<1, carry=a[WIDTH-1].
  - 111 SHR (logical): result=a>>1, carry=a[0].
- FSM states:
  - IDLE: start=1 and ena=1 at an edge latches a, b, op and cin, clears counter -> RUN.
  - RUN: each edge with ena=1 processes bit[counter] (sum=a^b'^c, c=maj), shifts the result bit in at the MSB, and increments counter. At the edge where counter==WIDTH-1 -> DONE, with result, carry, zero and ovf written.
  - DONE: lasts exactly one cycle with ena=1 -> IDLE. A start sampled in DONE is accepted exactly as in IDLE (back-to-back ops).
- Handshake:
  - busy=1 in RUN only.
  - done=1 in DONE only.
  - done rises in the same cycle busy falls.
- Latency: start sampled at edge t0 -> done high after edge tWIDTH, i.e. WIDTH cycles with ena=1 continuously.
- ovf = carry into MSB XOR carry out of MSB.
- zero is accumulated serially (OR of produced bits) and inverted at DONE.
- Flags update only on DONE; result, flags and carry are held otherwise.
- Logic ops leave carry unchanged and set ovf=0.
- ADC with carry_flag=1 is the only way flag state crosses operations.
- start while busy is ignored and does not corrupt latched operands. Input changes during RUN have no effect.
- ena=0: no state, counter or output change; done stays high for as long as ena=0 while in DONE.
- rst_n low mid-RUN: immediate return to reset values, no done pulse. First start after release is accepted normally.
- op, a and b are only ever sampled at accepted start.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 -> done exactly 8 cycles after start; result=0x80, carry=0, ovf=1, zero=0; busy high 8 cycles.
- SUB a=0x05 b=0x05 -> result=0x00, carry=1, zero=1, ovf=0. Then SUB a=0x03 b=0x05 -> result=0xFE, carry=0, zero=0.
- ADD 0xFF+0x01 (result=0x00, carry=1, zero=1), back-to-back start in the DONE cycle with ADC 0x10+0x20 -> result=0x31, carry=0.
- SHL a=0x81 -> result=0x02, carry=1. SHR a=0x81 -> result=0x40, carry=1. AND 0xF0&0x3C -> 0x30, carry unchanged.
- ena low 3 cycles mid-RUN, plus start pulses and operand changes during RUN -> done 11 cycles after start, result unaffected. rst_n low at bit 4 -> all outputs 0, no done; next ADD 0x01+0x01 -> 0x02.
- WIDTH=16, ADD 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1, done after 16 cycles.
